// File: rtl/pluse_tick_gen.sv
// pluse_tick_gen: system time base. Divides clk_sys down to single-cycle
// strobes at 1 us, 1 ms and 1 s, keeps a free-running microsecond timestamp,
// and produces a run-time programmable periodic strobe counted in microseconds.
module pluse_tick_gen #(
    parameter int CLK_MHZ = 100,
    parameter int SIM     = 0,
    parameter int TS_W    = 32
) (
    input  logic            clk_sys,
    input  logic            rst,
    input  logic            en,
    input  logic [15:0]     prog_period,
    input  logic            prog_load,
    output logic            pluse_us,
    output logic            pluse_ms,
    output logic            pluse_s,
    output logic            pluse_prog,
    output logic [TS_W-1:0] ts_us
);

    // Divide ratios; simulation mode collapses the microsecond to one cycle
    localparam int         LEN_US_I = ((SIM != 0) ? 1 : CLK_MHZ) - 1;
    localparam int         N_MS_I   = (SIM != 0) ? 10 : 1000;
    localparam int         N_S_I    = (SIM != 0) ? 10 : 1000;
    localparam logic [7:0] LEN_US   = 8'(LEN_US_I);
    localparam logic [9:0] MS_LAST  = 10'(N_MS_I - 1);
    localparam logic [9:0] S_LAST   = 10'(N_S_I - 1);

    logic [7:0]      cnt_cycle_q, cnt_cycle_d;
    logic [9:0]      cnt_ms_q, cnt_ms_d;
    logic [9:0]      cnt_s_q, cnt_s_d;
    logic [15:0]     per_q, per_d;
    logic [15:0]     cnt_prog_q, cnt_prog_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            pluse_us_q, pluse_us_d;
    logic            pluse_ms_q, pluse_ms_d;
    logic            pluse_s_q, pluse_s_d;
    logic            pluse_prog_q, pluse_prog_d;

    logic us_tick, ms_tick, s_tick;

    // Tick cascade: each level only advances on the tick of the level below,
    // so a low en freezes every counter and preserves phase.
    always_comb begin
        us_tick = en && (cnt_cycle_q == LEN_US);
        ms_tick = us_tick && (cnt_ms_q == MS_LAST);
        s_tick  = ms_tick && (cnt_s_q == S_LAST);

        cnt_cycle_d = cnt_cycle_q;
        if (en) begin
            cnt_cycle_d = (cnt_cycle_q == LEN_US) ? 8'd0 : cnt_cycle_q + 8'd1;
        end

        cnt_ms_d = cnt_ms_q;
        if (us_tick) begin
            cnt_ms_d = ms_tick ? 10'd0 : cnt_ms_q + 10'd1;
        end

        cnt_s_d = cnt_s_q;
        if (ms_tick) begin
            cnt_s_d = s_tick ? 10'd0 : cnt_s_q + 10'd1;
        end

        ts_d = us_tick ? ts_q + TS_W'(1) : ts_q;

        pluse_us_d = us_tick;
        pluse_ms_d = ms_tick;
        pluse_s_d  = s_tick;
    end

    // Programmable strobe: a load restarts the period and swallows any tick
    // landing on the load edge; a zero period parks the counter.
    always_comb begin
        per_d        = per_q;
        cnt_prog_d   = cnt_prog_q;
        pluse_prog_d = 1'b0;
        if (prog_load) begin
            per_d      = prog_period;
            cnt_prog_d = 16'd0;
        end else if (per_q == 16'd0) begin
            cnt_prog_d = 16'd0;
        end else if (us_tick) begin
            if (cnt_prog_q == per_q - 16'd1) begin
                cnt_prog_d   = 16'd0;
                pluse_prog_d = 1'b1;
            end else begin
                cnt_prog_d = cnt_prog_q + 16'd1;
            end
        end
    end

    // State and registered strobes; reset wins over load and enable
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cnt_cycle_q  <= '0;
            cnt_ms_q     <= '0;
            cnt_s_q      <= '0;
            per_q        <= '0;
            cnt_prog_q   <= '0;
            ts_q         <= '0;
            pluse_us_q   <= 1'b0;
            pluse_ms_q   <= 1'b0;
            pluse_s_q    <= 1'b0;
            pluse_prog_q <= 1'b0;
        end else begin
            cnt_cycle_q  <= cnt_cycle_d;
            cnt_ms_q     <= cnt_ms_d;
            cnt_s_q      <= cnt_s_d;
            per_q        <= per_d;
            cnt_prog_q   <= cnt_prog_d;
            ts_q         <= ts_d;
            pluse_us_q   <= pluse_us_d;
            pluse_ms_q   <= pluse_ms_d;
            pluse_s_q    <= pluse_s_d;
            pluse_prog_q <= pluse_prog_d;
        end
    end

    assign pluse_us   = pluse_us_q;
    assign pluse_ms   = pluse_ms_q;
    assign pluse_s    = pluse_s_q;
    assign pluse_prog = pluse_prog_q;
    assign ts_us      = ts_q;

endmodule

// File: tb/tb_pluse_tick_gen.sv
// Bench for pluse_tick_gen: three instances (100 MHz real, 100 MHz SIM with a
// 4-bit timestamp, 4 MHz real) checked every cycle against an arithmetic model
// of enabled-edge and microsecond counts, plus directed literal checks.
module tb_pluse_tick_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic rst0 = 1'b1, en0 = 1'b0, ld0 = 1'b0; logic [15:0] pp0 = '0;
    logic rst1 = 1'b1, en1 = 1'b0, ld1 = 1'b0; logic [15:0] pp1 = '0;
    logic rst2 = 1'b1, en2 = 1'b0, ld2 = 1'b0; logic [15:0] pp2 = '0;
    logic on0 = 1'b0, on1 = 1'b0, on2 = 1'b0;

    logic        us0, ms0, s0, pg0; logic [31:0] ts0;
    logic        us1, ms1, s1, pg1; logic [3:0]  ts1;
    logic        us2, ms2, s2, pg2; logic [15:0] ts2;

    pluse_tick_gen #(.CLK_MHZ(100), .SIM(0), .TS_W(32)) u0 (
        .clk_sys(clk), .rst(rst0), .en(en0), .prog_period(pp0), .prog_load(ld0),
        .pluse_us(us0), .pluse_ms(ms0), .pluse_s(s0), .pluse_prog(pg0), .ts_us(ts0));
    pluse_tick_gen #(.CLK_MHZ(100), .SIM(1), .TS_W(4)) u1 (
        .clk_sys(clk), .rst(rst1), .en(en1), .prog_period(pp1), .prog_load(ld1),
        .pluse_us(us1), .pluse_ms(ms1), .pluse_s(s1), .pluse_prog(pg1), .ts_us(ts1));
    pluse_tick_gen #(.CLK_MHZ(4), .SIM(0), .TS_W(16)) u2 (
        .clk_sys(clk), .rst(rst2), .en(en2), .prog_period(pp2), .prog_load(ld2),
        .pluse_us(us2), .pluse_ms(ms2), .pluse_s(s2), .pluse_prog(pg2), .ts_us(ts2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: E = enabled edges since reset, U = microseconds since reset.
    // A us tick happens on every R-th enabled edge; ms/s ticks are the ticks
    // where U is a multiple of N_MS / N_MS*N_S; prog fires when the number of
    // ticks since the load edge is a multiple of the period.
    longint m_e[3], m_u[3], m_ul[3];
    longint m_per[3];
    logic   e_us[3], e_ms[3], e_s[3], e_pg[3];
    longint e_ts[3];

    task automatic model_step(input int i, input longint r, input longint nms,
                              input longint ns, input int tsw, input logic rs,
                              input logic en, input logic ld, input logic [15:0] pp);
        logic tk;
        if (rs) begin
            m_e[i] = 0; m_u[i] = 0; m_ul[i] = 0; m_per[i] = 0;
            e_us[i] = 0; e_ms[i] = 0; e_s[i] = 0; e_pg[i] = 0; e_ts[i] = 0;
            return;
        end
        tk = 1'b0;
        if (en) begin
            m_e[i]++;
            if (m_e[i] % r == 0) begin
                tk = 1'b1;
                m_u[i]++;
            end
        end
        e_us[i] = tk;
        e_ms[i] = tk && (m_u[i] % nms == 0);
        e_s[i]  = tk && (m_u[i] % (nms * ns) == 0);
        e_ts[i] = m_u[i] & ((longint'(1) << tsw) - 1);
        if (ld) begin
            m_per[i] = longint'(pp);
            m_ul[i]  = m_u[i];
            e_pg[i]  = 1'b0;
        end else begin
            e_pg[i] = tk && (m_per[i] != 0) && ((m_u[i] - m_ul[i]) % m_per[i] == 0);
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 100, 1000, 1000, 32, rst0, en0, ld0, pp0);
        model_step(1, 1,   10,   10,   4,  rst1, en1, ld1, pp1);
        model_step(2, 4,   1000, 1000, 16, rst2, en2, ld2, pp2);
    end

    // Cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (on0) begin
            chk("u0_us", 64'(us0), 64'(e_us[0])); chk("u0_ms", 64'(ms0), 64'(e_ms[0]));
            chk("u0_s", 64'(s0), 64'(e_s[0]));    chk("u0_prog", 64'(pg0), 64'(e_pg[0]));
            chk("u0_ts", 64'(ts0), 64'(e_ts[0]));
        end
        if (on1) begin
            chk("u1_us", 64'(us1), 64'(e_us[1])); chk("u1_ms", 64'(ms1), 64'(e_ms[1]));
            chk("u1_s", 64'(s1), 64'(e_s[1]));    chk("u1_prog", 64'(pg1), 64'(e_pg[1]));
            chk("u1_ts", 64'(ts1), 64'(e_ts[1]));
        end
        if (on2) begin
            chk("u2_us", 64'(us2), 64'(e_us[2])); chk("u2_ms", 64'(ms2), 64'(e_ms[2]));
            chk("u2_s", 64'(s2), 64'(e_s[2]));    chk("u2_prog", 64'(pg2), 64'(e_pg[2]));
            chk("u2_ts", 64'(ts2), 64'(e_ts[2]));
        end
    end

    // Advance n active edges, then settle 1 time unit past the last one
    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            // 100 MHz: basic period, timestamp, mid-run reset, prog in real time
            begin
                tick_n(1); on0 = 1'b1;
                chk("a_rst_us", 64'(us0), 0); chk("a_rst_ts", 64'(ts0), 0);
                chk("a_rst_prog", 64'(pg0), 0);
                tick_n(1); rst0 = 1'b0; en0 = 1'b1;
                tick_n(99);  chk("a_e99_us", 64'(us0), 0);
                tick_n(1);   chk("a_e100_us", 64'(us0), 1); chk("a_e100_ts", 64'(ts0), 1);
                tick_n(1);   chk("a_e101_us", 64'(us0), 0); chk("a_e101_ts", 64'(ts0), 1);
                tick_n(99);  chk("a_e200_us", 64'(us0), 1); chk("a_e200_ts", 64'(ts0), 2);
                tick_n(100); chk("a_e300_us", 64'(us0), 1); chk("a_e300_ts", 64'(ts0), 3);
                tick_n(37);  rst0 = 1'b1;
                tick_n(1);   rst0 = 1'b0;
                chk("a_mrst_us", 64'(us0), 0); chk("a_mrst_ts", 64'(ts0), 0);
                tick_n(99);  chk("a_rel99_us", 64'(us0), 0);
                tick_n(1);   chk("a_rel100_us", 64'(us0), 1); chk("a_rel100_ts", 64'(ts0), 1);
                ld0 = 1'b1; pp0 = 16'd2;
                tick_n(1);   ld0 = 1'b0;
                tick_n(198); chk("a_prog_e299", 64'(pg0), 0);
                tick_n(1);   chk("a_prog_e300", 64'(pg0), 1); chk("a_prog_ts", 64'(ts0), 3);
            end
            // SIM=1: hierarchy, programmable period, timestamp wrap
            begin
                tick_n(1); on1 = 1'b1;
                tick_n(1); rst1 = 1'b0; en1 = 1'b1;
                tick_n(1);  chk("b_e1_us", 64'(us1), 1); chk("b_e1_ts", 64'(ts1), 1);
                tick_n(3);  ld1 = 1'b1; pp1 = 16'd3;
                tick_n(1);  ld1 = 1'b0;
                chk("b_e5_prog", 64'(pg1), 0); chk("b_e5_ts", 64'(ts1), 5);
                tick_n(3);  chk("b_e8_prog", 64'(pg1), 1);
                tick_n(1);  chk("b_e9_prog", 64'(pg1), 0); chk("b_e9_ms", 64'(ms1), 0);
                tick_n(1);  chk("b_e10_ms", 64'(ms1), 1);
                tick_n(1);  chk("b_e11_prog", 64'(pg1), 1);
                tick_n(3);  chk("b_e14_prog", 64'(pg1), 1);
                tick_n(1);  chk("b_e15_ts", 64'(ts1), 15);
                tick_n(1);  chk("b_e16_ts", 64'(ts1), 0);
                tick_n(4);  chk("b_e20_ms", 64'(ms1), 1);
                tick_n(80); chk("b_e100_s", 64'(s1), 1); chk("b_e100_ms", 64'(ms1), 1);
                chk("b_e100_us", 64'(us1), 1);
                tick_n(1);  chk("b_e101_s", 64'(s1), 0);
                ld1 = 1'b1; pp1 = 16'd0;
                tick_n(1);  ld1 = 1'b0;
                for (int k = 0; k < 30; k++) begin
                    tick_n(1);
                    if (k % 10 == 0) chk("b_zero_prog", 64'(pg1), 0);
                end
                en1 = 1'b0;
                tick_n(1);  chk("b_off_us", 64'(us1), 0);
                ld1 = 1'b1; pp1 = 16'd2;
                tick_n(1);  ld1 = 1'b0;
                tick_n(3);  en1 = 1'b1;
                tick_n(1);  chk("b_on_us", 64'(us1), 1); chk("b_on1_prog", 64'(pg1), 0);
                tick_n(1);  chk("b_on2_prog", 64'(pg1), 1);
            end
            // 4 MHz: enable gap preserves phase and timestamp
            begin
                tick_n(1); on2 = 1'b1;
                tick_n(1); rst2 = 1'b0; en2 = 1'b1;
                tick_n(4);  chk("c_e4_us", 64'(us2), 1); chk("c_e4_ts", 64'(ts2), 1);
                tick_n(2);  en2 = 1'b0;
                for (int k = 0; k < 7; k++) begin
                    tick_n(1);
                    chk("c_gap_us", 64'(us2), 0); chk("c_gap_ts", 64'(ts2), 1);
                end
                en2 = 1'b1;
                tick_n(1);  chk("c_ret1_us", 64'(us2), 0);
                tick_n(1);  chk("c_ret2_us", 64'(us2), 1); chk("c_ret2_ts", 64'(ts2), 2);
                tick_n(20);
            end
        join
        tick_n(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
